// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: 2-flop rx synchronizer, oversampled start validation,
// mid-bit data sampling (LSB first) and stop-bit check with framing-error report.
module uart_rx_deserializer #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 done,
  output logic                 busy,
  output logic                 frame_err
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [SW-1:0] HALF_M1  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_M1  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $error("uart_rx_deserializer: OVERSAMPLE must be even and >= 4");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_busy;
  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic [SW-1:0]        r_scnt;
  logic [SW-1:0]        w_scnt_nxt;
  logic [BW-1:0]        r_bidx;
  logic [BW-1:0]        w_bidx_nxt;
  logic [DATA_BITS-1:0] r_shreg;
  logic [DATA_BITS-1:0] w_shreg_nxt;
  logic                 r_armed;
  logic                 w_armed_nxt;
  logic [DATA_BITS-1:0] r_data;
  logic [DATA_BITS-1:0] w_data_nxt;
  logic                 r_done;
  logic                 w_done_nxt;
  logic                 r_ferr;
  logic                 w_ferr_nxt;

  // rx is asynchronous to clk; both stages idle high so reset looks like a quiet line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (tick) begin
      case (r_state)
        S_IDLE:  if (r_armed && !r_rx_s) w_state_nxt = S_START;
        S_START: if (r_scnt == HALF_M1) w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
        S_DATA:  if (r_scnt == FULL_M1 && r_bidx == LAST_BIT) w_state_nxt = S_STOP;
        S_STOP:  if (r_scnt == FULL_M1) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_scnt_nxt  = r_scnt;
    w_bidx_nxt  = r_bidx;
    w_shreg_nxt = r_shreg;
    w_armed_nxt = r_armed;
    w_data_nxt  = r_data;
    w_ferr_nxt  = r_ferr;
    w_done_nxt  = 1'b0;
    if (tick) begin
      case (r_state)
        S_IDLE: begin
          // a start is only honoured once the line has been seen idle-high
          if (r_rx_s) begin
            w_armed_nxt = 1'b1;
          end else if (r_armed) begin
            w_scnt_nxt = '0;
          end
        end
        S_START: begin
          if (r_scnt == HALF_M1) begin
            if (!r_rx_s) begin
              w_scnt_nxt = '0;
              w_bidx_nxt = '0;
            end
          end else begin
            w_scnt_nxt = r_scnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_scnt == FULL_M1) begin
            w_shreg_nxt                = r_shreg >> 1;
            w_shreg_nxt[DATA_BITS-1]   = r_rx_s;
            w_scnt_nxt                 = '0;
            if (r_bidx != LAST_BIT) w_bidx_nxt = r_bidx + 1'b1;
          end else begin
            w_scnt_nxt = r_scnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_scnt == FULL_M1) begin
            w_data_nxt = r_shreg;
            w_ferr_nxt = !r_rx_s;
            w_done_nxt = 1'b1;
            if (!r_rx_s) w_armed_nxt = 1'b0;
          end else begin
            w_scnt_nxt = r_scnt + 1'b1;
          end
        end
        default: w_scnt_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scnt  <= '0;
      r_bidx  <= '0;
      r_shreg <= '0;
      r_armed <= 1'b0;
      r_data  <= '0;
      r_ferr  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_scnt  <= w_scnt_nxt;
      r_bidx  <= w_bidx_nxt;
      r_shreg <= w_shreg_nxt;
      r_armed <= w_armed_nxt;
      r_data  <= w_data_nxt;
      r_ferr  <= w_ferr_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign data_out  = r_data;
  assign done      = r_done;
  assign busy      = r_busy;
  assign frame_err = r_ferr;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed + randomized bench for uart_rx_deserializer; expected bytes come from
// the transmitted frame content (byte, stop level), not from the receiver's internals.
module tb_uart_rx_deserializer;

  localparam int unsigned OS = 16;
  localparam int unsigned DB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic          rx;
  logic [DB-1:0] data_out;
  logic          done;
  logic          busy;
  logic          frame_err;

  uart_rx_deserializer #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .rx        (rx),
    .data_out  (data_out),
    .done      (done),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned tick_div = 4;
  int unsigned busy_ticks;
  int unsigned n_done_long = 0;
  int unsigned n_done_busy = 0;
  logic        busy_seen;
  logic        done_prev = 1'b0;
  logic [8:0]  exp_q[$];
  logic [8:0]  got_q[$];
  logic [8:0]  res1[$];
  logic [8:0]  res7[$];
  logic [7:0]  rbyte[5];
  logic        rstop[5];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // one clk; outputs are observed 1 time unit after the rising edge
  task automatic clk_cycle();
    logic busy_before;
    busy_before = busy;
    @(posedge clk);
    #1;
    if (tick && (busy_before || busy)) busy_ticks++;
    if (busy) busy_seen = 1'b1;
    if (done) begin
      got_q.push_back({frame_err, data_out});
      if (busy) n_done_busy++;
      if (done_prev) n_done_long++;
    end
    done_prev = done;
  endtask

  task automatic do_tick();
    tick = 1'b0;
    repeat (tick_div - 1) clk_cycle();
    tick = 1'b1;
    clk_cycle();
    tick = 1'b0;
  endtask

  task automatic send_bits(input logic lvl, input int unsigned nticks);
    rx = lvl;
    repeat (nticks) do_tick();
  endtask

  task automatic idle(input int unsigned nticks);
    send_bits(1'b1, nticks);
  endtask

  // reference: a cleanly timed frame is received as the byte sent, error = stop level low
  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bits(1'b0, OS);
    for (int i = 0; i < DB; i++) send_bits(b[i], OS);
    send_bits(stop, OS);
    exp_q.push_back({!stop, b});
  endtask

  task automatic check_frames(input string tag);
    int unsigned n;
    check($sformatf("%s frame count", tag), got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s data[%0d]", tag, i), {24'd0, got_q[i][7:0]}, {24'd0, exp_q[i][7:0]});
      check($sformatf("%s frame_err[%0d]", tag, i), {31'd0, got_q[i][8]}, {31'd0, exp_q[i][8]});
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst  = 1'b1;
    rx   = 1'b1;
    tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset data_out", {24'd0, data_out}, 32'h0);
    check("reset done", {31'd0, done}, 32'h0);
    check("reset busy", {31'd0, busy}, 32'h0);
    check("reset frame_err", {31'd0, frame_err}, 32'h0);
    rst = 1'b0;

    // basic frame
    tick_div = 4;
    idle(20);
    busy_ticks = 0;
    send_frame(8'hA5, 1'b1);
    idle(20);
    check_frames("basic");
    check("basic busy ticks", busy_ticks, 32'd153);

    // back-to-back
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(20);
    check_frames("b2b");

    // glitch: first tick of low is T0 (tick_div covers sync latency)
    busy_seen = 1'b0;
    send_bits(1'b0, 4);
    send_bits(1'b1, 4);
    check("glitch busy at T0+7", {31'd0, busy}, 32'h1);
    do_tick();
    check("glitch busy at T0+8", {31'd0, busy}, 32'h0);
    check("glitch busy seen", {31'd0, busy_seen}, 32'h1);
    idle(20);
    check_frames("glitch");
    send_frame(8'h55, 1'b1);
    idle(20);
    check_frames("post-glitch");

    // framing error, then break
    send_frame(8'h81, 1'b0);
    idle(20);
    check_frames("ferr");
    send_bits(1'b0, 30 * OS);
    exp_q.push_back({1'b1, 8'h00});
    check_frames("break");
    idle(20);
    send_frame(8'h5A, 1'b1);
    idle(20);
    check_frames("post-break");

    // reset during bit 4 of 0xC3
    send_bits(1'b0, OS);
    for (int i = 0; i < 4; i++) send_bits(((8'hC3 >> i) & 8'h1) != 0, OS);
    send_bits(1'b0, 5);
    check("pre-reset busy", {31'd0, busy}, 32'h1);
    rst = 1'b1;
    #1;
    check("mid rst data_out", {24'd0, data_out}, 32'h0);
    check("mid rst busy", {31'd0, busy}, 32'h0);
    check("mid rst done", {31'd0, done}, 32'h0);
    check("mid rst frame_err", {31'd0, frame_err}, 32'h0);
    send_bits(1'b0, 2);
    rst = 1'b0;
    send_bits(1'b0, 40);
    check("post rst busy", {31'd0, busy}, 32'h0);
    check_frames("rst no frame");
    idle(20);
    send_frame(8'h42, 1'b1);
    idle(20);
    check_frames("post-rst");

    // tick spacing: same random frames at tick every clk and every 7 clk
    for (int i = 0; i < 5; i++) begin
      rbyte[i] = 8'($urandom);
      rstop[i] = ($urandom_range(0, 3) != 0);
    end
    for (int pass = 0; pass < 2; pass++) begin
      tick_div = (pass == 0) ? 1 : 7;
      idle(20);
      for (int i = 0; i < 5; i++) begin
        send_frame(rbyte[i], rstop[i]);
        if (!rstop[i]) idle(20);
      end
      idle(20);
      if (pass == 0) res1 = got_q;
      else res7 = got_q;
      check_frames($sformatf("rand div%0d", tick_div));
    end
    check("spacing result count", res1.size(), res7.size());
    for (int i = 0; i < res1.size() && i < res7.size(); i++)
      check($sformatf("spacing result[%0d]", i), {23'd0, res1[i]}, {23'd0, res7[i]});

    check("done one-cycle", n_done_long, 32'd0);
    check("busy low with done", n_done_busy, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
